mult_share_arbiter: RTL

//  Shares one 4x4 signed shift-add multiplier (start/done handshake, 8-bit product) among
//  N_REQ requesters. Round-robin arbitration; sequences start, waits for done, captures

---
 rtl/mult_share_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one 4x4 signed multiplier among N_REQ requesters.
// Sequences the start/done handshake, captures the 8-bit product and returns a one-hot response.
//
// state   | meaning
// IDLE    | waiting for any req; arbitrates and latches operands
// START   | mul_start high for this cycle only; timer cleared
// BUSY    | waiting for mul_done, timer running toward timeout
// CAPTURE | mul_c is valid now; product registered
// RESP    | drives the one-hot response next cycle; round-robin pointer advances
module mult_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   a_in,
  input  logic [4*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_err,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic [7:0]           mul_c
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic [TW-1:0]   timer;
  logic            err_q;
  logic            found;
  logic [IW-1:0]   pick;
  int              idx;

  // First requester after rr_ptr, wrapping; works for non-power-of-two N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      timer     <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
      grant     <= '0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= pick;
            mul_a     <= a_in[int'(pick)*4 +: 4];
            mul_b     <= b_in[int'(pick)*4 +: 4];
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          err_q <= 1'b0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          timer <= timer + 1'b1;
          // A done arriving on the expiry cycle still counts as success.
          if (mul_done) begin
            state <= S_CAPTURE;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            err_q    <= 1'b1;
            rsp_data <= '0;
            state    <= S_RESP;
          end
        end
        S_CAPTURE: begin
          rsp_data <= mul_c;
          state    <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= N_REQ'(1) << grant;
          rsp_err   <= err_q;
          rr_ptr    <= grant;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
